// File: rtl/mem_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mem_stream_bridge
// Brief   : Serializes cache-line requests into header/data beats and
//           reassembles read-response beats into full lines.
// Rev     : 1.0  initial parametrised release
// ============================================================================
module mem_stream_bridge #(
  parameter int LINE_W  = 512,
  parameter int BEAT_W  = 128,
  parameter int ADDR_W  = 26,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  output logic                         getMReq_en,
  input  logic                         getMReq_rdy,
  input  logic [ADDR_W+LINE_W:0]       getMReq_data,
  output logic [BEAT_W-1:0]            req_axis_data,
  output logic                         req_axis_tuser,
  output logic                         req_axis_valid,
  input  logic                         req_axis_ready,
  input  logic [BEAT_W-1:0]            resp_axis_data,
  input  logic                         resp_axis_valid,
  input  logic                         resp_axis_tuser,
  output logic                         resp_axis_ready,
  output logic [LINE_W-1:0]            putMResp_data,
  output logic                         putMResp_en,
  input  logic                         putMResp_rdy,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_out,
  output logic                         err_unexpected_out,
  output logic                         err_dropped_out
);

  localparam int c_BEATS = LINE_W / BEAT_W;
  localparam int c_IDX_W = $clog2(c_BEATS);
  localparam int c_OUT_W = $clog2(MAX_OUT + 1);
  localparam int c_REQ_W = 1 + ADDR_W + LINE_W;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BEATS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [c_OUT_W-1:0] c_MAX_OUT  = c_OUT_W'(MAX_OUT);
  localparam logic [c_OUT_W-1:0] c_OUT_ONE  = c_OUT_W'(1);
  localparam logic [26:0]        c_HDR_LEN  = 27'(c_BEATS);

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_HDR  = 2'd1,
    SER_DATA = 2'd2
  } ser_state_t;

  typedef enum logic [1:0] {
    ACC_EMPTY = 2'd0,
    ACC_FILL  = 2'd1,
    ACC_FULL  = 2'd2
  } acc_state_t;

  ser_state_t          r_ser_state, w_ser_next;
  logic                r_req_write;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [LINE_W-1:0]   r_req_line;
  logic [c_IDX_W-1:0]  r_tx_idx, w_tx_idx_next;
  logic                w_rd_issue;
  logic                w_req_write_in;
  logic [26:0]         w_hdr_addr;
  logic [54:0]         w_hdr;

  acc_state_t          r_acc_state, w_acc_next;
  logic [c_IDX_W-1:0]  r_rx_idx, w_rx_idx_next;
  logic [LINE_W-1:0]   r_acc_line;
  logic                w_beat_acc;
  logic                w_beat_store;
  logic                w_line_done;

  logic [c_OUT_W-1:0]  r_outstanding;
  logic                r_err_unexp;
  logic                r_err_drop;

  assign w_req_write_in = getMReq_data[c_REQ_W-1];
  // Header address field is the byte-beat address, truncated to 27 bits.
  assign w_hdr_addr     = 27'(r_req_addr) << c_IDX_W;
  assign w_hdr          = {w_hdr_addr, c_HDR_LEN, r_req_write};

  // ------------------------------------------------------------------ serializer
  always_comb begin
    w_ser_next     = r_ser_state;
    w_tx_idx_next  = r_tx_idx;
    w_rd_issue     = 1'b0;
    getMReq_en     = 1'b0;
    req_axis_valid = 1'b0;
    req_axis_tuser = 1'b0;
    req_axis_data  = '0;
    case (r_ser_state)
      SER_IDLE: begin
        // Writes bypass the credit gate; only reads consume a slot.
        getMReq_en = rst_n_in && getMReq_rdy &&
                     (w_req_write_in || (r_outstanding < c_MAX_OUT));
        if (getMReq_en) w_ser_next = SER_HDR;
      end
      SER_HDR: begin
        req_axis_valid = 1'b1;
        req_axis_tuser = 1'b1;
        req_axis_data  = BEAT_W'(w_hdr);
        if (req_axis_ready) begin
          if (r_req_write) begin
            w_ser_next    = SER_DATA;
            w_tx_idx_next = '0;
          end else begin
            w_ser_next = SER_IDLE;
            w_rd_issue = 1'b1;
          end
        end
      end
      SER_DATA: begin
        req_axis_valid = 1'b1;
        req_axis_data  = r_req_line[r_tx_idx*BEAT_W +: BEAT_W];
        if (req_axis_ready) begin
          if (r_tx_idx == c_LAST_IDX) begin
            w_ser_next    = SER_IDLE;
            w_tx_idx_next = '0;
          end else begin
            w_tx_idx_next = r_tx_idx + c_IDX_ONE;
          end
        end
      end
      default: w_ser_next = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ser_state <= SER_IDLE;
      r_tx_idx    <= '0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_line  <= '0;
    end else begin
      r_ser_state <= w_ser_next;
      r_tx_idx    <= w_tx_idx_next;
      if (getMReq_en) begin
        r_req_write <= w_req_write_in;
        r_req_addr  <= getMReq_data[LINE_W +: ADDR_W];
        r_req_line  <= getMReq_data[LINE_W-1:0];
      end
    end
  end

  // ----------------------------------------------------------------- accumulator
  always_comb begin
    w_acc_next      = r_acc_state;
    w_rx_idx_next   = r_rx_idx;
    resp_axis_ready = 1'b0;
    putMResp_en     = 1'b0;
    w_beat_acc      = 1'b0;
    w_beat_store    = 1'b0;
    w_line_done     = 1'b0;
    case (r_acc_state)
      ACC_EMPTY, ACC_FILL: begin
        resp_axis_ready = rst_n_in;
        w_beat_acc      = resp_axis_valid && resp_axis_ready;
        w_beat_store    = w_beat_acc && !resp_axis_tuser;
        if (w_beat_store) begin
          if (r_rx_idx == c_LAST_IDX) begin
            w_acc_next    = ACC_FULL;
            w_rx_idx_next = '0;
          end else begin
            w_acc_next    = ACC_FILL;
            w_rx_idx_next = r_rx_idx + c_IDX_ONE;
          end
        end
      end
      ACC_FULL: begin
        putMResp_en = putMResp_rdy;
        w_line_done = putMResp_rdy;
        if (putMResp_rdy) w_acc_next = ACC_EMPTY;
      end
      default: w_acc_next = ACC_EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_acc_state <= ACC_EMPTY;
      r_rx_idx    <= '0;
      r_acc_line  <= '0;
      r_err_unexp <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      r_acc_state <= w_acc_next;
      r_rx_idx    <= w_rx_idx_next;
      if (w_beat_store) r_acc_line[r_rx_idx*BEAT_W +: BEAT_W] <= resp_axis_data;
      if (w_beat_acc && (r_outstanding == '0)) r_err_unexp <= 1'b1;
      if (w_beat_acc && resp_axis_tuser)       r_err_drop  <= 1'b1;
    end
  end

  // ---------------------------------------------------------- outstanding count
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_issue, w_line_done})
        2'b10:   r_outstanding <= r_outstanding + c_OUT_ONE;
        2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - c_OUT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign putMResp_data      = r_acc_line;
  assign outstanding_out    = r_outstanding;
  assign err_unexpected_out = r_err_unexp;
  assign err_dropped_out    = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stream_bridge
// Brief   : Randomized bench for mem_stream_bridge against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_stream_bridge;

  localparam int LINE_W  = 512;
  localparam int BEAT_W  = 128;
  localparam int ADDR_W  = 26;
  localparam int MAX_OUT = 4;
  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int REQ_W   = 1 + ADDR_W + LINE_W;
  localparam int SREQ_W  = 1 + ADDR_W + 256;

  typedef logic [LINE_W-1:0] val_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } req_t;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              getMReq_en, getMReq_rdy;
  logic [REQ_W-1:0]  getMReq_data;
  logic [BEAT_W-1:0] req_axis_data;
  logic              req_axis_tuser, req_axis_valid, req_axis_ready;
  logic [BEAT_W-1:0] resp_axis_data;
  logic              resp_axis_valid, resp_axis_tuser, resp_axis_ready;
  logic [LINE_W-1:0] putMResp_data;
  logic              putMResp_en, putMResp_rdy;
  logic [2:0]        outstanding_out;
  logic              err_unexpected_out, err_dropped_out;

  logic              small_go;
  logic [SREQ_W-1:0] small_req;
  logic              s64_en, s64_tuser, s64_valid, s64_rrdy, s64_put, s64_eu, s64_ed;
  logic [63:0]       s64_data;
  logic [255:0]      s64_line;
  logic [2:0]        s64_out;
  logic              s128_en, s128_tuser, s128_valid, s128_rrdy, s128_put, s128_eu, s128_ed;
  logic [127:0]      s128_data;
  logic [255:0]      s128_line;
  logic [2:0]        s128_out;

  always #5 clk_in = ~clk_in;

  mem_stream_bridge #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .getMReq_en(getMReq_en), .getMReq_rdy(getMReq_rdy), .getMReq_data(getMReq_data),
    .req_axis_data(req_axis_data), .req_axis_tuser(req_axis_tuser),
    .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
    .resp_axis_data(resp_axis_data), .resp_axis_valid(resp_axis_valid),
    .resp_axis_tuser(resp_axis_tuser), .resp_axis_ready(resp_axis_ready),
    .putMResp_data(putMResp_data), .putMResp_en(putMResp_en), .putMResp_rdy(putMResp_rdy),
    .outstanding_out(outstanding_out),
    .err_unexpected_out(err_unexpected_out), .err_dropped_out(err_dropped_out)
  );

  mem_stream_bridge #(.LINE_W(256), .BEAT_W(64), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) u_w64 (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .getMReq_en(s64_en), .getMReq_rdy(small_go), .getMReq_data(small_req),
    .req_axis_data(s64_data), .req_axis_tuser(s64_tuser),
    .req_axis_valid(s64_valid), .req_axis_ready(1'b1),
    .resp_axis_data(64'd0), .resp_axis_valid(1'b0),
    .resp_axis_tuser(1'b0), .resp_axis_ready(s64_rrdy),
    .putMResp_data(s64_line), .putMResp_en(s64_put), .putMResp_rdy(1'b1),
    .outstanding_out(s64_out),
    .err_unexpected_out(s64_eu), .err_dropped_out(s64_ed)
  );

  mem_stream_bridge #(.LINE_W(256), .BEAT_W(128), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) u_w128 (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .getMReq_en(s128_en), .getMReq_rdy(small_go), .getMReq_data(small_req),
    .req_axis_data(s128_data), .req_axis_tuser(s128_tuser),
    .req_axis_valid(s128_valid), .req_axis_ready(1'b1),
    .resp_axis_data(128'd0), .resp_axis_valid(1'b0),
    .resp_axis_tuser(1'b0), .resp_axis_ready(s128_rrdy),
    .putMResp_data(s128_line), .putMResp_en(s128_put), .putMResp_rdy(1'b1),
    .outstanding_out(s128_out),
    .err_unexpected_out(s128_eu), .err_dropped_out(s128_ed)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  req_t              pend_q[$];
  logic [BEAT_W:0]   exp_beats[$];
  logic [BEAT_W:0]   rsp_src[$];
  logic [BEAT_W-1:0] rx_beats[$];
  logic [LINE_W-1:0] line_q[$];
  int                m_out = 0;
  bit                m_unexp = 1'b0;
  bit                m_drop = 1'b0;
  int                n_en_dut = 0;
  logic [BEAT_W-1:0] last_hdr = '0;
  logic [LINE_W-1:0] last_line = '0;
  int p_req_rdy = 100, p_ds_rdy = 100, p_rsp_valid = 100, p_put_rdy = 100;
  bit auto_rsp = 1'b0;

  task automatic check_val(input string tag, input val_t obs, input val_t exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] hdr_of(input logic wr, input logic [ADDR_W-1:0] a, input int beats);
    logic [63:0] la;
    la = (64'(a) * 64'(beats)) % 64'h800_0000;
    return (BEAT_W'(la) << 28) + (BEAT_W'(beats) << 1) + BEAT_W'(wr);
  endfunction

  function automatic logic [BEAT_W-1:0] fill_beat(input logic [3:0] n);
    return {32{n}};
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] b;
    for (int w = 0; w < BEAT_W/32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.wr   = 1'($urandom_range(0, 1));
    r.addr = ADDR_W'($urandom);
    for (int w = 0; w < LINE_W/32; w++) r.line[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_inputs();
    if (auto_rsp && rsp_src.size() == 0 && rx_beats.size() == 0 &&
        line_q.size() == 0 && m_out > 0 && $urandom_range(0, 3) == 0) begin
      for (int k = 0; k < BEATS; k++) begin
        if ($urandom_range(0, 7) == 0) rsp_src.push_back({1'b1, rand_beat()});
        rsp_src.push_back({1'b0, rand_beat()});
      end
    end
    getMReq_rdy     = (pend_q.size() > 0) && ($urandom_range(0, 99) < p_req_rdy);
    getMReq_data    = (pend_q.size() > 0) ? pend_q[0] : '0;
    req_axis_ready  = ($urandom_range(0, 99) < p_ds_rdy);
    resp_axis_valid = (rsp_src.size() > 0) && ($urandom_range(0, 99) < p_rsp_valid);
    {resp_axis_tuser, resp_axis_data} = (rsp_src.size() > 0) ? rsp_src[0] : '0;
    putMResp_rdy    = ($urandom_range(0, 99) < p_put_rdy);
  endtask

  // Runs at the falling edge: checks outputs, then advances the model to the next rising edge.
  task automatic observe();
    bit   exp_en, exp_full;
    int   inc;
    req_t r;
    logic [LINE_W-1:0] ln;
    exp_full = (line_q.size() != 0);
    exp_en   = (exp_beats.size() == 0) && getMReq_rdy &&
               (getMReq_data[REQ_W-1] || (m_out < MAX_OUT));
    check_val("getMReq_en", val_t'(getMReq_en), val_t'(exp_en));
    check_val("req_valid", val_t'(req_axis_valid), val_t'(exp_beats.size() != 0));
    check_val("resp_ready", val_t'(resp_axis_ready), val_t'(!exp_full));
    check_val("put_en", val_t'(putMResp_en), val_t'(exp_full && putMResp_rdy));
    check_val("outstanding", val_t'(outstanding_out), val_t'(m_out));
    check_val("err_unexp", val_t'(err_unexpected_out), val_t'(m_unexp));
    check_val("err_drop", val_t'(err_dropped_out), val_t'(m_drop));
    if (getMReq_en) n_en_dut++;
    inc = 0;
    if (req_axis_valid && req_axis_ready && exp_beats.size() != 0) begin
      check_val("req_data", val_t'(req_axis_data), val_t'(exp_beats[0][BEAT_W-1:0]));
      check_val("req_tuser", val_t'(req_axis_tuser), val_t'(exp_beats[0][BEAT_W]));
      if (req_axis_tuser) last_hdr = req_axis_data;
      if (exp_beats[0][BEAT_W] && !exp_beats[0][0]) inc = 1;
      void'(exp_beats.pop_front());
    end
    if (exp_en && pend_q.size() > 0) begin
      r = pend_q.pop_front();
      exp_beats.push_back({1'b1, hdr_of(r.wr, r.addr, BEATS)});
      if (r.wr) for (int k = 0; k < BEATS; k++) exp_beats.push_back({1'b0, r.line[k*BEAT_W +: BEAT_W]});
    end
    if (resp_axis_valid && !exp_full && rsp_src.size() > 0) begin
      if (m_out == 0) m_unexp = 1'b1;
      if (resp_axis_tuser) m_drop = 1'b1;
      else begin
        rx_beats.push_back(resp_axis_data);
        if (rx_beats.size() == BEATS) begin
          for (int k = 0; k < BEATS; k++) ln[k*BEAT_W +: BEAT_W] = rx_beats[k];
          line_q.push_back(ln);
          rx_beats.delete();
        end
      end
      void'(rsp_src.pop_front());
    end
    if (exp_full && putMResp_rdy) begin
      check_val("put_data", putMResp_data, line_q[0]);
      last_line = putMResp_data;
      void'(line_q.pop_front());
      if (m_out > 0) m_out--;
    end
    m_out += inc;
  endtask

  // Entered and left just after a rising edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      @(negedge clk_in);
      if (rst_n_in) observe();
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check_all_zero();
    check_val("rst_getMReq_en", val_t'(getMReq_en), '0);
    check_val("rst_req_valid", val_t'(req_axis_valid), '0);
    check_val("rst_req_tuser", val_t'(req_axis_tuser), '0);
    check_val("rst_req_data", val_t'(req_axis_data), '0);
    check_val("rst_resp_ready", val_t'(resp_axis_ready), '0);
    check_val("rst_put_en", val_t'(putMResp_en), '0);
    check_val("rst_put_data", putMResp_data, '0);
    check_val("rst_outstanding", val_t'(outstanding_out), '0);
    check_val("rst_err_unexp", val_t'(err_unexpected_out), '0);
    check_val("rst_err_drop", val_t'(err_dropped_out), '0);
  endtask

  task automatic async_reset();
    #2 rst_n_in = 1'b0;
    #1;
    check_all_zero();
    exp_beats.delete(); rx_beats.delete(); line_q.delete(); rsp_src.delete();
    m_out = 0; m_unexp = 1'b0; m_drop = 1'b0;
    getMReq_rdy = 1'b0; resp_axis_valid = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  initial begin
    req_t r;
    int en0;
    logic [LINE_W-1:0] exp_line;
    logic [BEAT_W-1:0] h, bq[$];
    logic [63:0] h64;
    small_go = 1'b0;
    small_req = {1'b0, 26'd5, 256'd0};
    getMReq_rdy = 1'b1; getMReq_data = '0; req_axis_ready = 1'b0;
    resp_axis_valid = 1'b1; resp_axis_tuser = 1'b0; resp_axis_data = '0; putMResp_rdy = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_all_zero();
    getMReq_rdy = 1'b0; resp_axis_valid = 1'b0; putMResp_rdy = 1'b0;
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // Narrower instances: read of line address 5
    small_go = 1'b1;
    @(posedge clk_in);
    #1 small_go = 1'b0;
    @(negedge clk_in);
    h = hdr_of(1'b0, 26'd5, 4);
    h64 = h[63:0];
    check_val("w64_hdr_valid", val_t'(s64_valid & s64_tuser), val_t'(1));
    check_val("w64_hdr", val_t'(s64_data), val_t'(h64));
    check_val("w64_hdr_const", val_t'(s64_data), val_t'(64'h1_4000_0008));
    h = hdr_of(1'b0, 26'd5, 2);
    check_val("w128_hdr_valid", val_t'(s128_valid & s128_tuser), val_t'(1));
    check_val("w128_hdr", val_t'(s128_data), val_t'(h));
    check_val("w128_hdr_const", val_t'(s128_data), val_t'(128'hA000_0004));
    @(posedge clk_in);
    #1;
    check_val("w64_out", val_t'(s64_out), val_t'(1));
    check_val("w128_out", val_t'(s128_out), val_t'(1));

    // Write at 0x10, beat k filled with k+1
    r.wr = 1'b1; r.addr = 26'h10;
    for (int k = 0; k < BEATS; k++) r.line[k*BEAT_W +: BEAT_W] = fill_beat(4'(k + 1));
    pend_q.push_back(r);
    en0 = n_en_dut;
    run_cycles(10);
    check_val("wr_en_pulses", val_t'(n_en_dut - en0), val_t'(1));
    check_val("wr_hdr_const", val_t'(last_hdr), val_t'(128'h4_0000_0009));

    // Read at the maximum address
    r.wr = 1'b0; r.addr = 26'h3FF_FFFF; r.line = '0;
    pend_q.push_back(r);
    run_cycles(6);
    check_val("rd_hdr_const", val_t'(last_hdr), val_t'(128'h7FF_FFFC_000_0008));
    check_val("rd_out_one", val_t'(outstanding_out), val_t'(1));
    for (int k = 0; k < BEATS; k++) rsp_src.push_back({1'b0, rand_beat()});
    run_cycles(10);

    // Credit limit
    r.wr = 1'b0;
    for (int i = 0; i < 4; i++) begin r.addr = ADDR_W'(i); pend_q.push_back(r); end
    en0 = n_en_dut;
    run_cycles(12);
    check_val("credit_out4", val_t'(outstanding_out), val_t'(4));
    check_val("credit_en4", val_t'(n_en_dut - en0), val_t'(4));
    pend_q.push_back(rand_req());
    pend_q[0].wr = 1'b1;
    en0 = n_en_dut;
    run_cycles(10);
    check_val("credit_wr_pass", val_t'(n_en_dut - en0), val_t'(1));
    r.addr = 26'h123; pend_q.push_back(r);
    en0 = n_en_dut;
    run_cycles(10);
    check_val("credit_rd_block", val_t'(n_en_dut - en0), val_t'(0));
    p_put_rdy = 0;
    for (int k = 0; k < BEATS; k++) begin
      h = fill_beat(4'(10 + k));
      rsp_src.push_back({1'b0, h});
      exp_line[k*BEAT_W +: BEAT_W] = h;
    end
    run_cycles(6);
    check_val("full_ready_low", val_t'(resp_axis_ready), val_t'(0));
    check_val("full_put_low", val_t'(putMResp_en), val_t'(0));
    p_put_rdy = 100;
    run_cycles(1);
    check_val("full_line_dcba", last_line, exp_line);
    run_cycles(6);
    check_val("credit_rd_resume", val_t'(n_en_dut - en0), val_t'(1));
    auto_rsp = 1'b1;
    run_cycles(60);
    auto_rsp = 1'b0;
    check_val("drained_out0", val_t'(outstanding_out), val_t'(0));

    // Error flags
    for (int k = 0; k < BEATS + 1; k++) begin
      h = rand_beat();
      rsp_src.push_back({k == 1, h});
      if (k != 1) bq.push_back(h);
    end
    run_cycles(2);
    check_val("unexp_set", val_t'(err_unexpected_out), val_t'(1));
    run_cycles(8);
    for (int k = 0; k < BEATS; k++) exp_line[k*BEAT_W +: BEAT_W] = bq[k];
    check_val("drop_set", val_t'(err_dropped_out), val_t'(1));
    check_val("drop_slot_kept", last_line, exp_line);
    check_val("unexp_sticky", val_t'(err_unexpected_out), val_t'(1));

    // Reset during a write burst at beat 2
    pend_q.push_back(rand_req());
    pend_q[0].wr = 1'b1;
    for (int i = 0; i < 20 && exp_beats.size() != 2; i++) run_cycles(1);
    check_val("mid_write_reached", val_t'(exp_beats.size() == 2), val_t'(1));
    async_reset();
    pend_q.push_back(rand_req());
    pend_q[0].wr = 1'b1;
    run_cycles(12);
    // Reset with a partial response line
    rsp_src.push_back({1'b0, rand_beat()});
    rsp_src.push_back({1'b0, rand_beat()});
    run_cycles(4);
    async_reset();
    bq.delete();
    for (int k = 0; k < BEATS; k++) begin
      h = rand_beat();
      rsp_src.push_back({1'b0, h});
      exp_line[k*BEAT_W +: BEAT_W] = h;
    end
    run_cycles(8);
    check_val("post_rst_line", last_line, exp_line);

    // Randomized traffic
    auto_rsp = 1'b1;
    for (int i = 0; i < 80; i++) pend_q.push_back(rand_req());
    for (int blk = 0; blk < 20; blk++) begin
      p_req_rdy   = $urandom_range(30, 100);
      p_ds_rdy    = $urandom_range(30, 100);
      p_rsp_valid = $urandom_range(30, 100);
      p_put_rdy   = $urandom_range(30, 100);
      run_cycles(100);
    end
    p_req_rdy = 100; p_ds_rdy = 100; p_rsp_valid = 100; p_put_rdy = 100;
    run_cycles(300);
    check_val("rand_all_issued", val_t'(pend_q.size()), val_t'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
